// File: rtl/sh_host_mem_arb.sv
// Multi-channel host-memory model: round-robin request arbitration, fixed read latency,
// credit-limited in-order tagged responses from a single shared word-addressed memory.
module sh_host_mem_arb #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 8,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W    = $clog2(RSP_DEPTH + 1)
) (
    input  logic                       clk_main_a0,
    input  logic                       rst_main_n,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH-1:0]          req_wr,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [CH_W-1:0]            rsp_ch,
    output logic                       rsp_wr,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [CNT_W-1:0]           outstanding
);
    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic              wr;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [DATA_W-1:0] mem [DEPTH];
    rsp_t              fifo_mem [RSP_DEPTH];

    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    logic              credit_ok, grant;
    logic [CH_W-1:0]   grant_ch, cand;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              sel_wr;
    rsp_t              acc_rsp, push_rsp, head;
    logic              push_vld, pop, fifo_empty, fifo_full;

    // Credit counts requests in the pipeline and FIFO; a pop frees its credit one cycle later.
    assign credit_ok = rst_main_n && (outstanding_q < CNT_W'(RSP_DEPTH));

    always_comb begin
        grant     = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        req_ready = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        sel_wr    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(rr_ptr_q) + k >= NUM_CH) cand = CH_W'(int'(rr_ptr_q) + k - NUM_CH);
            else                              cand = CH_W'(int'(rr_ptr_q) + k);
            if (!grant && credit_ok && req_valid[cand]) begin
                grant    = 1'b1;
                grant_ch = cand;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant && grant_ch == CH_W'(i)) begin
                req_ready[i] = 1'b1;
                sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata    = req_wdata[i*DATA_W +: DATA_W];
                sel_wstrb    = req_wstrb[i*STRB_W +: STRB_W];
                sel_wr       = req_wr[i];
            end
        end
        acc_rsp.ch   = grant_ch;
        acc_rsp.wr   = sel_wr;
        acc_rsp.data = sel_wr ? '0 : mem[sel_addr];
    end

    always_ff @(posedge clk_main_a0) begin
        if (grant && sel_wr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (sel_wstrb[b]) mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_direct
            always_comb begin
                push_vld = grant;
                push_rsp = acc_rsp;
            end
        end else begin : g_pipe
            localparam int NS = RD_LAT - 1;
            logic [NS-1:0] vld_q, vld_d;
            rsp_t          pipe_q [NS];
            rsp_t          pipe_d [NS];

            always_comb begin
                vld_d[0]  = grant;
                pipe_d[0] = acc_rsp;
                for (int s = 1; s < NS; s++) begin
                    vld_d[s]  = vld_q[s-1];
                    pipe_d[s] = pipe_q[s-1];
                end
            end

            always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
                if (!rst_main_n) begin
                    vld_q <= '0;
                    for (int s = 0; s < NS; s++) pipe_q[s] <= '0;
                end else begin
                    vld_q  <= vld_d;
                    pipe_q <= pipe_d;
                end
            end

            always_comb begin
                push_vld = vld_q[NS-1];
                push_rsp = pipe_q[NS-1];
            end
        end
    endgenerate

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = !fifo_empty && rsp_ready;
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push_vld};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        rr_ptr_d = rr_ptr_q;
        if (grant) rr_ptr_d = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
        outstanding_d = outstanding_q;
        if (grant && !pop)      outstanding_d = outstanding_q + CNT_W'(1);
        else if (!grant && pop) outstanding_d = outstanding_q - CNT_W'(1);
    end

    always_ff @(posedge clk_main_a0) begin
        if (push_vld) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_rsp;
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Head storage is not reset, so the response fields are forced to zero while empty.
    assign rsp_valid   = !fifo_empty;
    assign rsp_ch      = fifo_empty ? '0 : head.ch;
    assign rsp_wr      = fifo_empty ? 1'b0 : head.wr;
    assign rsp_rdata   = fifo_empty ? '0 : head.data;
    assign outstanding = outstanding_q;

    a_ready_onehot0: assert property (@(posedge clk_main_a0) disable iff (!rst_main_n)
        $onehot0(req_ready));
    a_fifo_no_overflow: assert property (@(posedge clk_main_a0) disable iff (!rst_main_n)
        !(push_vld && fifo_full && !pop));
    a_credit_limit: assert property (@(posedge clk_main_a0) disable iff (!rst_main_n)
        outstanding_q <= CNT_W'(RSP_DEPTH));
endmodule

// File: tb/tb_sh_host_mem_arb.sv
// Directed bench for sh_host_mem_arb: default 4-channel build plus a 1-channel RD_LAT=1 build.
module tb_sh_host_mem_arb;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic clk_main_a0 = 1'b0;
    logic rst_main_n;

    logic [NUM_CH-1:0]        req_valid, req_ready, req_wr;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH*STRB_W-1:0] req_wstrb;
    logic                     rsp_valid, rsp_ready, rsp_wr;
    logic [1:0]               rsp_ch;
    logic [DATA_W-1:0]        rsp_rdata;
    logic [3:0]               outstanding;

    logic              b_req_valid, b_req_ready, b_req_wr;
    logic [ADDR_W-1:0] b_req_addr;
    logic [DATA_W-1:0] b_req_wdata;
    logic [STRB_W-1:0] b_req_wstrb;
    logic              b_rsp_valid, b_rsp_ready, b_rsp_wr;
    logic              b_rsp_ch;
    logic [DATA_W-1:0] b_rsp_rdata;
    logic [3:0]        b_outstanding;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_main_a0 = ~clk_main_a0;

    sh_host_mem_arb dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch),
        .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .outstanding(outstanding)
    );

    sh_host_mem_arb #(.NUM_CH(1), .RD_LAT(1)) dut_b (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_ch(b_rsp_ch),
        .rsp_wr(b_rsp_wr), .rsp_rdata(b_rsp_rdata), .outstanding(b_outstanding)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
        req_wr[ch]                      = wr;
        req_addr[ch*ADDR_W +: ADDR_W]   = addr;
        req_wdata[ch*DATA_W +: DATA_W]  = data;
        req_wstrb[ch*STRB_W +: STRB_W]  = strb;
        req_valid[ch]                   = 1'b1;
    endtask

    // Issue one request and wait (bounded) for its grant; returns at posedge+1.
    task automatic do_req(input int ch, input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
        logic got;
        got = 1'b0;
        set_req(ch, wr, addr, data, strb);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_main_a0);
            if (req_ready[ch]) begin
                got = 1'b1;
                break;
            end
            @(posedge clk_main_a0); #1;
        end
        check_eq("req_granted", 64'(got), 64'd1);
        @(posedge clk_main_a0); #1;
        req_valid[ch] = 1'b0;
    endtask

    // Wait (bounded) for a response, check it, pop it; rsp_ready is left low.
    task automatic get_rsp(input string tag, input logic [1:0] ch, input logic wr,
                           input logic [DATA_W-1:0] data);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_main_a0);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check_eq({tag, "_seen"}, 64'(got), 64'd1);
        check_eq({tag, "_ch"}, 64'(rsp_ch), 64'(ch));
        check_eq({tag, "_wr"}, 64'(rsp_wr), 64'(wr));
        check_eq({tag, "_rdata"}, 64'(rsp_rdata), 64'(data));
        rsp_ready = 1'b1;
        @(posedge clk_main_a0); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [DATA_W-1:0] exp_d;

        req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_req_wstrb = '0; b_rsp_ready = 1'b1;
        rst_main_n = 1'b1;
        #1 rst_main_n = 1'b0;

        // Reset state, with requests pending
        req_valid = 4'hF;
        repeat (2) @(posedge clk_main_a0);
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_outstanding", 64'(outstanding), 64'd0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_eq("rst_rsp_ch", 64'(rsp_ch), 64'd0);
        req_valid = '0;
        @(posedge clk_main_a0); #1;
        rst_main_n = 1'b1;

        // ch2 write then read of addr 0x05, exact latency
        set_req(2, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
        @(negedge clk_main_a0);
        check_eq("wr_ready", 64'(req_ready), 64'b0100);
        check_eq("wr_no_early_rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk_main_a0); #1;
        req_wr[2] = 1'b0;
        @(negedge clk_main_a0);
        check_eq("rd_ready", 64'(req_ready), 64'b0100);
        check_eq("rd_outstanding", 64'(outstanding), 64'd1);
        check_eq("wr_ack_not_at_T1", 64'(rsp_valid), 64'd0);
        @(posedge clk_main_a0); #1;
        req_valid = '0;
        @(negedge clk_main_a0);
        check_eq("ack_valid", 64'(rsp_valid), 64'd1);
        check_eq("ack_ch", 64'(rsp_ch), 64'd2);
        check_eq("ack_wr", 64'(rsp_wr), 64'd1);
        check_eq("ack_rdata", 64'(rsp_rdata), 64'd0);
        check_eq("ack_outstanding", 64'(outstanding), 64'd2);
        @(posedge clk_main_a0); #1;
        @(negedge clk_main_a0);
        check_eq("rd_valid", 64'(rsp_valid), 64'd1);
        check_eq("rd_ch", 64'(rsp_ch), 64'd2);
        check_eq("rd_wr", 64'(rsp_wr), 64'd0);
        check_eq("rd_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        check_eq("rd_outstanding", 64'(outstanding), 64'd1);
        @(posedge clk_main_a0); #1;
        @(negedge clk_main_a0);
        check_eq("idle_valid", 64'(rsp_valid), 64'd0);
        check_eq("idle_outstanding", 64'(outstanding), 64'd0);
        @(posedge clk_main_a0); #1;

        // Partial strobe merge on addr 0x3FF
        rsp_ready = 1'b0;
        do_req(3, 1'b1, 10'h3FF, 32'h11223344, 4'hF);
        do_req(3, 1'b1, 10'h3FF, 32'hAABBCCDD, 4'h5);
        do_req(3, 1'b0, 10'h3FF, 32'h0, 4'h0);
        get_rsp("strb_ack0", 2'd3, 1'b1, 32'h0);
        get_rsp("strb_ack1", 2'd3, 1'b1, 32'h0);
        get_rsp("strb_read", 2'd3, 1'b0, 32'h11BB33DD);

        // Credit backpressure on ch1
        set_req(1, 1'b0, 10'h005, 32'h0, 4'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_main_a0);
            if (req_ready[1]) cnt++;
            @(posedge clk_main_a0); #1;
        end
        check_eq("credit_grants", 64'(cnt), 64'd8);
        @(negedge clk_main_a0);
        check_eq("credit_outstanding_full", 64'(outstanding), 64'd8);
        check_eq("credit_head_ch", 64'(rsp_ch), 64'd1);
        check_eq("credit_head_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        rsp_ready = 1'b1;
        #1;
        check_eq("credit_no_grant_on_pop", 64'(req_ready), 64'd0);
        @(posedge clk_main_a0); #1;
        rsp_ready = 1'b0;
        @(negedge clk_main_a0);
        check_eq("credit_regrant", 64'(req_ready), 64'b0010);
        check_eq("credit_after_pop", 64'(outstanding), 64'd7);
        @(posedge clk_main_a0); #1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_main_a0);
            if (req_ready[1]) cnt++;
            @(posedge clk_main_a0); #1;
        end
        check_eq("credit_single_regrant", 64'(cnt), 64'd0);
        check_eq("credit_refull", 64'(outstanding), 64'd8);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (15) @(posedge clk_main_a0);
        #1;
        check_eq("drain_outstanding", 64'(outstanding), 64'd0);
        check_eq("drain_valid", 64'(rsp_valid), 64'd0);

        // Reset with three responses queued
        rsp_ready = 1'b0;
        do_req(0, 1'b0, 10'h005, 32'h0, 4'h0);
        do_req(1, 1'b0, 10'h3FF, 32'h0, 4'h0);
        do_req(2, 1'b0, 10'h005, 32'h0, 4'h0);
        repeat (3) @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        check_eq("queued_outstanding", 64'(outstanding), 64'd3);
        check_eq("queued_valid", 64'(rsp_valid), 64'd1);
        #1 rst_main_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(rsp_valid), 64'd0);
        check_eq("async_rst_outstanding", 64'(outstanding), 64'd0);
        @(posedge clk_main_a0);
        @(posedge clk_main_a0); #1;
        rst_main_n = 1'b1;
        rsp_ready = 1'b1;

        // All four channels read together from reset
        set_req(0, 1'b0, 10'h005, 32'h0, 4'h0);
        set_req(1, 1'b0, 10'h3FF, 32'h0, 4'h0);
        set_req(2, 1'b0, 10'h005, 32'h0, 4'h0);
        set_req(3, 1'b0, 10'h3FF, 32'h0, 4'h0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk_main_a0);
            check_eq($sformatf("rr_ready_c%0d", c), 64'(req_ready),
                     (c < 4) ? (64'd1 << c) : 64'd0);
            check_eq($sformatf("rr_rsp_valid_c%0d", c), 64'(rsp_valid),
                     (c >= 2 && c < 6) ? 64'd1 : 64'd0);
            if (c >= 2 && c < 6) begin
                exp_d = ((c - 2) % 2 == 0) ? 32'hDEADBEEF : 32'h11BB33DD;
                check_eq($sformatf("rr_rsp_ch_c%0d", c), 64'(rsp_ch), 64'(c - 2));
                check_eq($sformatf("rr_rdata_c%0d", c), 64'(rsp_rdata), 64'(exp_d));
            end
            @(posedge clk_main_a0); #1;
            if (c < 4) req_valid[c] = 1'b0;
        end

        // Single-channel RD_LAT=1 build: back-to-back traffic
        b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = 10'h001;
        b_req_wdata = 32'h12345678; b_req_wstrb = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_main_a0);
            check_eq($sformatf("b_ready_c%0d", c), 64'(b_req_ready), (c < 4) ? 64'd1 : 64'd0);
            check_eq($sformatf("b_rsp_valid_c%0d", c), 64'(b_rsp_valid),
                     (c >= 1 && c < 5) ? 64'd1 : 64'd0);
            if (c >= 1 && c < 5) begin
                check_eq($sformatf("b_rsp_wr_c%0d", c), 64'(b_rsp_wr), (c == 1) ? 64'd1 : 64'd0);
                check_eq($sformatf("b_rdata_c%0d", c), 64'(b_rsp_rdata),
                         (c == 1) ? 64'd0 : 64'h12345678);
                check_eq($sformatf("b_rsp_ch_c%0d", c), 64'(b_rsp_ch), 64'd0);
            end
            @(posedge clk_main_a0); #1;
            b_req_wr = 1'b0;
            if (c == 3) b_req_valid = 1'b0;
        end
        check_eq("b_outstanding_end", 64'(b_outstanding), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
